// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared widths, RISC-V opcode constants and entry/bundle types for the
// Tomasulo reservation station and its priority encoder.
// Optional feature macro used by the top: RS_LSB_CDB_EN (second CDB port).
// -----------------------------------------------------------------------------
package reservation_station_pkg;

   localparam int Q_WIDTH      = 5;
   localparam int RS_SIZE      = 16;
   localparam int RS_IDX_WIDTH = 4;
   localparam int DATA_W       = 32;
   localparam int OPCODE_W     = 7;
   localparam int FUNC3_W      = 3;
   localparam int FUNC7_W      = 7;

   localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
   localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
   localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
   localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
   localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
   localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
   localparam logic [OPCODE_W-1:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;

   // Fields handed to EX on dispatch.
   typedef struct packed {
      logic [OPCODE_W-1:0] opcode;
      logic [FUNC3_W-1:0]  func3;
      logic [FUNC7_W-1:0]  func7;
      logic [DATA_W-1:0]   v1;
      logic [DATA_W-1:0]   v2;
      logic [DATA_W-1:0]   imm;
      logic [DATA_W-1:0]   npc;
      logic [Q_WIDTH-1:0]  rob;
   } ex_bundle_t;

   // One station slot: the EX bundle plus operand tracking.
   typedef struct packed {
      ex_bundle_t          op;
      logic [Q_WIDTH-1:0]  q1;
      logic [Q_WIDTH-1:0]  q2;
      logic                q1_busy;
      logic                q2_busy;
   } rs_entry_t;

endpackage

// File: rtl/reservation_station_priority_enc.sv
// -----------------------------------------------------------------------------
// rs_priority_enc
// Lowest-set-bit encoder used for free-slot and ready-slot selection.
// Ports:
//   i_req   [N-1:0]  request vector
//   o_idx   [W-1:0]  index of lowest set bit (0 when none set)
//   o_found          at least one request bit set
// -----------------------------------------------------------------------------
module rs_priority_enc
   import reservation_station_pkg::*;
#(
   parameter int N = RS_SIZE,
   parameter int W = RS_IDX_WIDTH
) (
   input  logic [N-1:0] i_req,
   output logic [W-1:0] o_idx,
   output logic         o_found
);

   // Scan from the top down so the lowest set bit is the last one written.
   always_comb begin
      o_idx   = '0;
      o_found = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = W'(i);
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Holds renamed instructions until both operands are available, snoops the
// CDB for missing operands and dispatches the lowest-index ready entry to EX
// each cycle as a registered bundle.
// Ports:
//   clk_in, rst_in (sync, active-high), rdy_in (freeze), clear_in (flush)
//   issue_*        : decoded instruction, operand values/tags/busy, imm, npc,
//                    destination ROB tag; issue_valid requests a write
//   rs_full        : every slot occupied
//   cdb_*          : ALU result broadcast (tag + value)
//   lsb_cdb_*      : second broadcast, present only with RS_LSB_CDB_EN
//   ex_*           : registered dispatch bundle, ex_valid marks a new one
// Optional feature macro: RS_LSB_CDB_EN
// -----------------------------------------------------------------------------
module reservation_station
   import reservation_station_pkg::*;
(
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 rdy_in,
   input  logic                 clear_in,

   input  logic                 issue_valid,
   input  logic [OPCODE_W-1:0]  issue_opcode,
   input  logic [FUNC3_W-1:0]   issue_func3,
   input  logic [FUNC7_W-1:0]   issue_func7,
   input  logic [DATA_W-1:0]    issue_V1,
   input  logic [DATA_W-1:0]    issue_V2,
   input  logic [Q_WIDTH-1:0]   issue_Q1,
   input  logic [Q_WIDTH-1:0]   issue_Q2,
   input  logic                 issue_Q1_busy,
   input  logic                 issue_Q2_busy,
   input  logic [DATA_W-1:0]    issue_immediate,
   input  logic [DATA_W-1:0]    issue_npc,
   input  logic [Q_WIDTH-1:0]   issue_ROB_pos,
   output logic                 rs_full,

   input  logic                 cdb_valid,
   input  logic [Q_WIDTH-1:0]   cdb_ROB_pos,
   input  logic [DATA_W-1:0]    cdb_V,
`ifdef RS_LSB_CDB_EN
   input  logic                 lsb_cdb_valid,
   input  logic [Q_WIDTH-1:0]   lsb_cdb_ROB_pos,
   input  logic [DATA_W-1:0]    lsb_cdb_V,
`endif

   output logic                 ex_valid,
   output logic [OPCODE_W-1:0]  ex_opcode,
   output logic [FUNC3_W-1:0]   ex_func3,
   output logic [FUNC7_W-1:0]   ex_func7,
   output logic [DATA_W-1:0]    ex_V1,
   output logic [DATA_W-1:0]    ex_V2,
   output logic [DATA_W-1:0]    ex_immediate,
   output logic [DATA_W-1:0]    ex_npc,
   output logic [Q_WIDTH-1:0]   ex_ROB_pos
);

   rs_entry_t                r_entry [RS_SIZE];
   logic [RS_SIZE-1:0]       r_busy;
   ex_bundle_t               r_ex_p1;
   logic                     r_ex_vld_p1;

   logic [RS_SIZE-1:0]       w_free;
   logic [RS_SIZE-1:0]       w_ready;
   logic [RS_IDX_WIDTH-1:0]  w_free_idx;
   logic [RS_IDX_WIDTH-1:0]  w_rdy_idx;
   logic                     w_free_found;
   logic                     w_rdy_found;
   logic [RS_SIZE-1:0]       w_issue_oh;
   logic [RS_SIZE-1:0]       w_disp_oh;
   logic [RS_SIZE-1:0]       w_busy_nxt;
   logic [DATA_W:0]          w_q1_m [RS_SIZE];
   logic [DATA_W:0]          w_q2_m [RS_SIZE];
   logic [DATA_W:0]          w_iss1_m;
   logic [DATA_W:0]          w_iss2_m;
   rs_entry_t                w_new;

   // Returns {hit, value} for a tag against the broadcast bus(es). The ALU
   // bus is checked last so it wins when both buses carry the same tag.
   function automatic logic [DATA_W:0] cdb_match(input logic [Q_WIDTH-1:0] q);
      logic [DATA_W:0] m;
      m = '0;
`ifdef RS_LSB_CDB_EN
      if (lsb_cdb_valid && (lsb_cdb_ROB_pos == q)) m = {1'b1, lsb_cdb_V};
`endif
      if (cdb_valid && (cdb_ROB_pos == q)) m = {1'b1, cdb_V};
      return m;
   endfunction

   always_comb begin
      for (int i = 0; i < RS_SIZE; i++) begin
         w_free[i]  = ~r_busy[i];
         w_ready[i] = r_busy[i] & ~r_entry[i].q1_busy & ~r_entry[i].q2_busy;
         w_q1_m[i]  = cdb_match(r_entry[i].q1);
         w_q2_m[i]  = cdb_match(r_entry[i].q2);
      end
   end

   rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_free_enc (
      .i_req   (w_free),
      .o_idx   (w_free_idx),
      .o_found (w_free_found)
   );

   rs_priority_enc #(.N(RS_SIZE), .W(RS_IDX_WIDTH)) u_ready_enc (
      .i_req   (w_ready),
      .o_idx   (w_rdy_idx),
      .o_found (w_rdy_found)
   );

   // New entry, with same-cycle CDB bypass into still-pending operands.
   always_comb begin
      w_iss1_m         = cdb_match(issue_Q1);
      w_iss2_m         = cdb_match(issue_Q2);
      w_new            = '0;
      w_new.op.opcode  = issue_opcode;
      w_new.op.func3   = issue_func3;
      w_new.op.func7   = issue_func7;
      w_new.op.imm     = issue_immediate;
      w_new.op.npc     = issue_npc;
      w_new.op.rob     = issue_ROB_pos;
      w_new.q1         = issue_Q1;
      w_new.q2         = issue_Q2;
      w_new.op.v1      = (issue_Q1_busy && w_iss1_m[DATA_W]) ? w_iss1_m[DATA_W-1:0] : issue_V1;
      w_new.op.v2      = (issue_Q2_busy && w_iss2_m[DATA_W]) ? w_iss2_m[DATA_W-1:0] : issue_V2;
      w_new.q1_busy    = issue_Q1_busy && !w_iss1_m[DATA_W];
      w_new.q2_busy    = issue_Q2_busy && !w_iss2_m[DATA_W];
   end

   // Free and ready slots come from pre-edge state, so the two one-hots can
   // never name the same slot.
   assign w_issue_oh = (issue_valid && w_free_found) ? (RS_SIZE'(1) << w_free_idx) : '0;
   assign w_disp_oh  = w_rdy_found ? (RS_SIZE'(1) << w_rdy_idx) : '0;
   assign w_busy_nxt = (r_busy & ~w_disp_oh) | w_issue_oh;

   // Stage p0 -> entry storage: wake-up and issue writes (no reset needed,
   // r_busy qualifies every slot).
   always_ff @(posedge clk_in) begin
      if (rdy_in && !clear_in) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (r_busy[i] && r_entry[i].q1_busy && w_q1_m[i][DATA_W]) begin
               r_entry[i].op.v1   <= w_q1_m[i][DATA_W-1:0];
               r_entry[i].q1_busy <= 1'b0;
            end
            if (r_busy[i] && r_entry[i].q2_busy && w_q2_m[i][DATA_W]) begin
               r_entry[i].op.v2   <= w_q2_m[i][DATA_W-1:0];
               r_entry[i].q2_busy <= 1'b0;
            end
         end
         if (w_issue_oh != '0) r_entry[w_free_idx] <= w_new;
      end
   end

   // Stage p1 -> dispatch register and occupancy.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_busy      <= '0;
         r_ex_vld_p1 <= 1'b0;
         r_ex_p1     <= '0;
      end else if (rdy_in) begin
         if (clear_in) begin
            r_busy      <= '0;
            r_ex_vld_p1 <= 1'b0;
         end else begin
            r_busy      <= w_busy_nxt;
            r_ex_vld_p1 <= w_rdy_found;
            if (w_rdy_found) r_ex_p1 <= r_entry[w_rdy_idx].op;
         end
      end else begin
         r_ex_vld_p1 <= 1'b0;
      end
   end

   assign rs_full      = &r_busy;
   assign ex_valid     = r_ex_vld_p1;
   assign ex_opcode    = r_ex_p1.opcode;
   assign ex_func3     = r_ex_p1.func3;
   assign ex_func7     = r_ex_p1.func7;
   assign ex_V1        = r_ex_p1.v1;
   assign ex_V2        = r_ex_p1.v2;
   assign ex_immediate = r_ex_p1.imm;
   assign ex_npc       = r_ex_p1.npc;
   assign ex_ROB_pos   = r_ex_p1.rob;

endmodule

// File: tb/tb_reservation_station.sv
module tb_reservation_station;
   import reservation_station_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst_in, rdy_in, clear_in;
   logic                issue_valid;
   logic [6:0]          issue_opcode;
   logic [2:0]          issue_func3;
   logic [6:0]          issue_func7;
   logic [31:0]         issue_V1, issue_V2, issue_immediate, issue_npc;
   logic [4:0]          issue_Q1, issue_Q2, issue_ROB_pos;
   logic                issue_Q1_busy, issue_Q2_busy;
   logic                rs_full;
   logic                cdb_valid;
   logic [4:0]          cdb_ROB_pos;
   logic [31:0]         cdb_V;
`ifdef RS_LSB_CDB_EN
   logic                lsb_cdb_valid;
   logic [4:0]          lsb_cdb_ROB_pos;
   logic [31:0]         lsb_cdb_V;
`endif
   logic                ex_valid;
   logic [6:0]          ex_opcode;
   logic [2:0]          ex_func3;
   logic [6:0]          ex_func7;
   logic [31:0]         ex_V1, ex_V2, ex_immediate, ex_npc;
   logic [4:0]          ex_ROB_pos;

   int n_cmp = 0;
   int n_err = 0;

   reservation_station dut (
      .clk_in          (clk),
      .rst_in          (rst_in),
      .rdy_in          (rdy_in),
      .clear_in        (clear_in),
      .issue_valid     (issue_valid),
      .issue_opcode    (issue_opcode),
      .issue_func3     (issue_func3),
      .issue_func7     (issue_func7),
      .issue_V1        (issue_V1),
      .issue_V2        (issue_V2),
      .issue_Q1        (issue_Q1),
      .issue_Q2        (issue_Q2),
      .issue_Q1_busy   (issue_Q1_busy),
      .issue_Q2_busy   (issue_Q2_busy),
      .issue_immediate (issue_immediate),
      .issue_npc       (issue_npc),
      .issue_ROB_pos   (issue_ROB_pos),
      .rs_full         (rs_full),
      .cdb_valid       (cdb_valid),
      .cdb_ROB_pos     (cdb_ROB_pos),
      .cdb_V           (cdb_V),
`ifdef RS_LSB_CDB_EN
      .lsb_cdb_valid   (lsb_cdb_valid),
      .lsb_cdb_ROB_pos (lsb_cdb_ROB_pos),
      .lsb_cdb_V       (lsb_cdb_V),
`endif
      .ex_valid        (ex_valid),
      .ex_opcode       (ex_opcode),
      .ex_func3        (ex_func3),
      .ex_func7        (ex_func7),
      .ex_V1           (ex_V1),
      .ex_V2           (ex_V2),
      .ex_immediate    (ex_immediate),
      .ex_npc          (ex_npc),
      .ex_ROB_pos      (ex_ROB_pos)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] v1, input logic [31:0] v2,
                            input logic [4:0] q1, input logic q1b,
                            input logic [4:0] q2, input logic q2b,
                            input logic [31:0] imm, input logic [31:0] npc,
                            input logic [4:0] rob);
      issue_valid     = 1'b1;
      issue_opcode    = op;
      issue_func3     = f3;
      issue_func7     = f7;
      issue_V1        = v1;
      issue_V2        = v2;
      issue_Q1        = q1;
      issue_Q1_busy   = q1b;
      issue_Q2        = q2;
      issue_Q2_busy   = q2b;
      issue_immediate = imm;
      issue_npc       = npc;
      issue_ROB_pos   = rob;
   endtask

   task automatic set_cdb(input logic v, input logic [4:0] tag, input logic [31:0] val);
      cdb_valid   = v;
      cdb_ROB_pos = tag;
      cdb_V       = val;
   endtask

   initial begin
      rst_in = 1'b1; rdy_in = 1'b1; clear_in = 1'b0;
      set_issue(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0);
      issue_valid = 1'b0;
      set_cdb(1'b0, 5'd0, 32'd0);
`ifdef RS_LSB_CDB_EN
      lsb_cdb_valid = 1'b0; lsb_cdb_ROB_pos = 5'd0; lsb_cdb_V = 32'd0;
`endif
      repeat (3) tick();
      chk("rst_ex_valid", ex_valid, 0);
      chk("rst_rs_full", rs_full, 0);
      chk("rst_ex_V1", ex_V1, 0);
      chk("rst_ex_imm", ex_immediate, 0);
      chk("rst_ex_rob", ex_ROB_pos, 0);
      rst_in = 1'b0;

      // ADDI, both operands ready
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'd5, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd7, 32'h104, 5'd3);
      tick();
      issue_valid = 1'b0;
      chk("t1_not_own_cycle", ex_valid, 0);
      tick();
      chk("t1_ex_valid", ex_valid, 1);
      chk("t1_ex_V1", ex_V1, 32'd5);
      chk("t1_ex_imm", ex_immediate, 32'd7);
      chk("t1_ex_rob", ex_ROB_pos, 5'd3);
      chk("t1_ex_opcode", ex_opcode, OPC_OP_IMM);
      chk("t1_ex_npc", ex_npc, 32'h104);
      tick();
      chk("t1_freed", ex_valid, 0);
      chk("t1_hold_V1", ex_V1, 32'd5);

      // Back-to-back issue while dispatching
      set_issue(OPC_OP, 3'd0, 7'h20, 32'h100, 32'h30, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd20);
      tick();
      set_issue(OPC_OP_IMM, 3'd4, 7'd0, 32'h200, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd9, 32'd0, 5'd21);
      tick();
      issue_valid = 1'b0;
      chk("tp_a_valid", ex_valid, 1);
      chk("tp_a_rob", ex_ROB_pos, 5'd20);
      chk("tp_a_func7", ex_func7, 7'h20);
      chk("tp_a_V2", ex_V2, 32'h30);
      tick();
      chk("tp_b_valid", ex_valid, 1);
      chk("tp_b_rob", ex_ROB_pos, 5'd21);
      chk("tp_b_func3", ex_func3, 3'd4);
      chk("tp_b_V1", ex_V1, 32'h200);
      tick();
      chk("tp_idle", ex_valid, 0);

      // Q1 pending, wrong tag first, then matching CDB
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'hDEAD, 32'd0, 5'd4, 1'b1, 5'd0, 1'b0, 32'd1, 32'd0, 5'd6);
      tick();
      issue_valid = 1'b0;
      set_cdb(1'b1, 5'd5, 32'h9999);
      tick();
      chk("t2_pending", ex_valid, 0);
      set_cdb(1'b1, 5'd4, 32'h1234);
      tick();
      set_cdb(1'b0, 5'd0, 32'd0);
      chk("t2_wrong_tag_no_wake", ex_valid, 0);
      tick();
      chk("t2_ex_valid", ex_valid, 1);
      chk("t2_ex_V1", ex_V1, 32'h1234);
      chk("t2_ex_rob", ex_ROB_pos, 5'd6);
      tick();
      chk("t2_done", ex_valid, 0);

      // Issue-edge bypass on Q2
      set_issue(OPC_OP, 3'd0, 7'd0, 32'h11, 32'd0, 5'd0, 1'b0, 5'd9, 1'b1, 32'd0, 32'd0, 5'd7);
      set_cdb(1'b1, 5'd9, 32'hABCD);
      tick();
      issue_valid = 1'b0;
      set_cdb(1'b0, 5'd0, 32'd0);
      chk("t3_not_own_cycle", ex_valid, 0);
      tick();
      chk("t3_ex_valid", ex_valid, 1);
      chk("t3_ex_V2", ex_V2, 32'hABCD);
      chk("t3_ex_V1", ex_V1, 32'h11);
      chk("t3_ex_rob", ex_ROB_pos, 5'd7);
      tick();
      chk("t3_done", ex_valid, 0);

      // Fill all 16 slots, blocked on tag 1
      for (int i = 0; i < 16; i++) begin
         set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'd0, 32'd0, 5'd1, 1'b1, 5'd0, 1'b0, 32'(i), 32'd0, 5'(16 + i));
         tick();
         chk("t4_fill_no_disp", ex_valid, 0);
      end
      issue_valid = 1'b0;
      chk("t4_full", rs_full, 1);
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'hEE, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd5);
      tick();
      issue_valid = 1'b0;
      chk("t4_full_after_17th", rs_full, 1);
      chk("t4_17th_no_disp", ex_valid, 0);
      set_cdb(1'b1, 5'd1, 32'h77);
      tick();
      set_cdb(1'b0, 5'd0, 32'd0);
      chk("t4_woken_not_yet", ex_valid, 0);
      tick();
      chk("t4_first_valid", ex_valid, 1);
      chk("t4_first_rob", ex_ROB_pos, 5'd16);
      chk("t4_first_V1", ex_V1, 32'h77);
      chk("t4_not_full", rs_full, 0);
      for (int k = 1; k < 16; k++) begin
         tick();
         chk("t4_seq_valid", ex_valid, 1);
         chk("t4_seq_rob", ex_ROB_pos, 32'(16 + k));
         chk("t4_seq_imm", ex_immediate, 32'(k));
      end
      tick();
      chk("t4_17th_ignored", ex_valid, 0);
      chk("t4_empty", rs_full, 0);

      // Flush with 5 pending and one ready entry
      for (int i = 0; i < 5; i++) begin
         set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'd0, 32'd0, 5'd2, 1'b1, 5'd0, 1'b0, 32'd0, 32'd0, 5'(i));
         tick();
      end
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'h42, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd10);
      tick();
      clear_in = 1'b1;
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'h43, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd11);
      tick();
      clear_in = 1'b0;
      issue_valid = 1'b0;
      chk("t5_clear_no_disp", ex_valid, 0);
      chk("t5_not_full", rs_full, 0);
      tick();
      chk("t5_clear_issue_dropped", ex_valid, 0);
      set_cdb(1'b1, 5'd2, 32'd1);
      tick();
      set_cdb(1'b0, 5'd0, 32'd0);
      chk("t5_cdb_no_disp_a", ex_valid, 0);
      tick();
      chk("t5_cdb_no_disp_b", ex_valid, 0);
      tick();
      chk("t5_cdb_no_disp_c", ex_valid, 0);

      // rdy_in low freezes a ready entry
      set_issue(OPC_OP_IMM, 3'd0, 7'd0, 32'h55, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd12);
      tick();
      issue_valid = 1'b0;
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_frozen", ex_valid, 0);
      end
      chk("t6_hold_rob", ex_ROB_pos, 5'd31);
      rdy_in = 1'b1;
      tick();
      chk("t6_valid", ex_valid, 1);
      chk("t6_rob", ex_ROB_pos, 5'd12);
      chk("t6_V1", ex_V1, 32'h55);
      tick();
      chk("t6_done", ex_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/reservation_station.md
# reservation_station

Operand-holding reservation station that feeds the combinational EX unit in the Tomasulo back end. Accepts decoded instructions from the issue stage with renamed operands, captures missing operands from the common data bus (CDB), and dispatches one ready entry per cycle to EX as a registered opcode/func/V1/V2/immediate/npc/ROB_pos bundle. Sits between the issue/rename logic and EX; EX's V/ROB_pos result returns here as the CDB.

## Interface
- Q_WIDTH, 5, ROB tag width
- RS_SIZE, 16, entry count (power of two)
- RS_IDX_WIDTH, 4, log2(RS_SIZE)

- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; low freezes all state
- clear_in  input  1  misprediction flush
- issue_valid  input  1  issue request this cycle
- issue_opcode / issue_func3 / issue_func7  input  7/3/7  decoded fields
- issue_V1, issue_V2  input  32 each  operand values (valid when not busy)
- issue_Q1, issue_Q2  input  Q_WIDTH each  producer ROB tags
- issue_Q1_busy, issue_Q2_busy  input  1 each  operand still pending
- issue_immediate, issue_npc  input  32 each
- issue_ROB_pos  input  Q_WIDTH  destination ROB tag
- rs_full  output  1  no free entry
- cdb_valid  input  1;  cdb_ROB_pos  input  Q_WIDTH;  cdb_V  input  32  ALU result broadcast
- ex_valid  output  1  dispatch bundle valid
- ex_opcode / ex_func3 / ex_func7  output  7/3/7
- ex_V1, ex_V2, ex_immediate, ex_npc  output  32 each
- ex_ROB_pos  output  Q_WIDTH

## Operation
- Entry: busy, op fields, V1/V2, Q1/Q2, Q1_busy/Q2_busy, immediate, npc, ROB_pos.
- Issue: when issue_valid and not rs_full, write lowest-index free entry (from pre-edge state). issue_valid while rs_full: ignored; issuer must not do this.
- Issue bypass: if an issued operand is busy and cdb_valid with cdb_ROB_pos == its Q, store cdb_V and clear that busy bit at the issue edge.
- Wake-up: every busy entry whose Qx_busy set and Qx == cdb_ROB_pos (cdb_valid) captures cdb_V, clears Qx_busy.
- Select: ready = busy & !Q1_busy & !Q2_busy (pre-edge state). Lowest-index ready entry dispatched: its fields registered onto ex_*, ex_valid=1, entry freed. No ready entry: ex_valid=0, ex_* data hold last value.
- Simultaneous issue + dispatch: both proceed; issue uses a free entry from pre-edge state, so the dispatched slot is not reused that cycle.
- rs_full = all entries busy, derived from registered state.
- clear_in (with rdy_in): all busy cleared, ex_valid=0 next cycle, same-cycle issue and dispatch discarded.
- rdy_in low: no entry change, ex_valid registered to 0. rst_in overrides clear_in and rdy_in.

## Timing
- Reset: all busy=0, rs_full=0, ex_valid=0, all ex_* data 0.
- Issue with both operands ready at edge E → eligible to select in cycle after E → ex_valid high from edge E+1.
- CDB in cycle N wakes last operand → ex_valid in cycle N+2.
- Throughput: one issue and one dispatch per cycle.
- Newly issued entry never dispatches in its own issue cycle.

## Configuration
- RS_LSB_CDB_EN: defined → second broadcast port lsb_cdb_valid (1), lsb_cdb_ROB_pos (Q_WIDTH), lsb_cdb_V (32) input; issue bypass and wake-up match both buses; if both carry the same tag, ALU CDB value wins. Undefined → ports absent, single CDB only.

## Structure
- Shared package/header: Q_WIDTH, RS_SIZE, RS_IDX_WIDTH, RISC-V opcode constants, entry field widths.
- One sub-module: rs_priority_enc (lowest-set-bit encoder, RS_SIZE → RS_IDX_WIDTH plus found flag), instantiated twice (free select, ready select).

## Test plan
- Reset, issue ADDI ROB_pos=3, V1=5, imm=7, no busy → ex_valid one cycle later with ex_V1=5, ex_immediate=7, ex_ROB_pos=3; entry freed.
- Issue Q1=4 busy; next cycle cdb_valid, tag 4, V=0x1234 → ex_valid two cycles after CDB, ex_V1=0x1234.
- Issue Q2=9 busy with cdb_valid tag 9, V=0xABCD same cycle → bypass; ex_valid next cycle, ex_V2=0xABCD.
- Fill 16 entries all blocked on tag 1 → rs_full=1, 17th issue ignored; broadcast tag 1 → entries dispatch lowest index first, one per cycle, rs_full drops after first dispatch.
- 5 pending entries, assert clear_in → ex_valid=0 next cycle, rs_full=0, later CDB tags cause no dispatch.
- rdy_in low for 3 cycles with ready entry → no dispatch; rdy_in high → dispatch next cycle.
